// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared configuration for the register-file writeback scheduler: address/data widths,
// arbiter states and the register one-hot helper.
package regfile_wb_scheduler_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;
  localparam int DATA_W     = 32;

  typedef enum logic [0:0] {
    ARB_NORMAL = 1'b0,
    ARB_DRAIN  = 1'b1
  } arb_state_t;

  // One-hot mask of a register; x0 never yields a bit since it can never be pending.
  function automatic logic [REG_COUNT-1:0] reg_mask(input logic [REG_ADDR_W-1:0] addr);
    logic [REG_COUNT-1:0] mask;
    mask    = {{(REG_COUNT-1){1'b0}}, 1'b1} << addr;
    mask[0] = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_scoreboard.sv
// Pending-result scoreboard: one bit per register with an outstanding long-latency
// result, plus RAW/WAW hazard detection against the registered vector.
module regfile_scoreboard
  import regfile_wb_scheduler_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  uses_rs1,
  input  logic                  uses_rs2,
  input  logic                  writes_rd,
  output logic                  raw_hazard,
  output logic                  waw_hazard
);

  logic [REG_COUNT-1:0] pending_r;
  logic [REG_COUNT-1:0] set_mask_s;
  logic [REG_COUNT-1:0] clr_mask_s;

  // Set/clear masks; set is applied after clear so a same-cycle collision leaves the bit set.
  always_comb begin
    set_mask_s = {REG_COUNT{1'b0}};
    clr_mask_s = {REG_COUNT{1'b0}};
    if (set_en) begin
      set_mask_s = reg_mask(set_rd);
    end else begin
      set_mask_s = {REG_COUNT{1'b0}};
    end
    if (clr_en) begin
      clr_mask_s = reg_mask(clr_rd);
    end else begin
      clr_mask_s = {REG_COUNT{1'b0}};
    end
  end

  // Pending vector register.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_r <= {REG_COUNT{1'b0}};
    end else begin
      pending_r <= ((pending_r & ~clr_mask_s) | set_mask_s) & ~{{(REG_COUNT-1){1'b0}}, 1'b1};
    end
  end

  // Hazard compare uses only the registered vector; no same-cycle release.
  always_comb begin
    raw_hazard = (uses_rs1 && pending_r[rs1]) || (uses_rs2 && pending_r[rs2]);
    waw_hazard = writes_rd && pending_r[rd];
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: fast/slow writeback arbitration with starvation
// drain, outstanding-op limit and issue stall. Optional perf counters under RF_WB_PERF_EN.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int STARVE_LIMIT    = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  issue_uses_rs1,
  input  logic                  issue_uses_rs2,
  input  logic                  issue_writes_rd,
  input  logic                  issue_long,
  output logic                  issue_stall,
  input  logic                  fast_valid,
  input  logic [REG_ADDR_W-1:0] fast_rd,
  input  logic [DATA_W-1:0]     fast_data,
  input  logic                  slow_valid,
  input  logic [REG_ADDR_W-1:0] slow_rd,
  input  logic [DATA_W-1:0]     slow_data,
  output logic                  slow_ready,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_rd_address,
  output logic [DATA_W-1:0]     rf_rd_data
`ifdef RF_WB_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_conflict_cycles
`endif
);

  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t          state_r, next_state_s;
  logic [OUT_W-1:0]    outstanding_r;
  logic [WAIT_W-1:0]   wait_cnt_r, next_wait_s;
  logic                raw_s, waw_s, full_s, slow_accept_s, long_issue_s, sel_valid_s;
  logic [REG_ADDR_W-1:0] sel_rd_s;

  regfile_scoreboard u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .set_en     (long_issue_s && issue_writes_rd),
    .set_rd     (issue_rd),
    .clr_en     (slow_accept_s),
    .clr_rd     (slow_rd),
    .rs1        (issue_rs1),
    .rs2        (issue_rs2),
    .rd         (issue_rd),
    .uses_rs1   (issue_uses_rs1),
    .uses_rs2   (issue_uses_rs2),
    .writes_rd  (issue_writes_rd),
    .raw_hazard (raw_s),
    .waw_hazard (waw_s)
  );

  // Issue stall, slow handshake and write-port selection (fast path always wins).
  always_comb begin
    full_s        = issue_long && (outstanding_r == OUT_W'(MAX_OUTSTANDING));
    issue_stall   = issue_valid && (raw_s || waw_s || full_s || (state_r == ARB_DRAIN));
    long_issue_s  = issue_valid && !issue_stall && issue_long;
    slow_ready    = !fast_valid;
    slow_accept_s = slow_valid && slow_ready;
    if (fast_valid) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = fast_rd;
      rf_rd_data  = fast_data;
    end else if (slow_accept_s) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = slow_rd;
      rf_rd_data  = slow_data;
    end else begin
      sel_valid_s = 1'b0;
      sel_rd_s    = {REG_ADDR_W{1'b0}};
      rf_rd_data  = {DATA_W{1'b0}};
    end
    rf_rd_address   = sel_rd_s;
    rf_write_enable = sel_valid_s && (sel_rd_s != {REG_ADDR_W{1'b0}});
  end

  // Arbiter next state: count consecutive refusals of slow_valid, drain once the limit is hit.
  always_comb begin
    next_state_s = state_r;
    next_wait_s  = wait_cnt_r;
    case (state_r)
      ARB_NORMAL: begin
        if (slow_accept_s || !slow_valid) begin
          next_wait_s = {WAIT_W{1'b0}};
        end else begin
          next_wait_s = wait_cnt_r + WAIT_W'(1);
          if (wait_cnt_r == WAIT_W'(STARVE_LIMIT - 1)) begin
            next_state_s = ARB_DRAIN;
          end else begin
            next_state_s = ARB_NORMAL;
          end
        end
      end
      ARB_DRAIN: begin
        if (slow_accept_s) begin
          next_state_s = ARB_NORMAL;
          next_wait_s  = {WAIT_W{1'b0}};
        end else begin
          next_state_s = ARB_DRAIN;
        end
      end
      default: begin
        next_state_s = ARB_NORMAL;
        next_wait_s  = {WAIT_W{1'b0}};
      end
    endcase
  end

  // Arbiter state, refusal counter and in-flight long-op count.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ARB_NORMAL;
      wait_cnt_r    <= {WAIT_W{1'b0}};
      outstanding_r <= {OUT_W{1'b0}};
    end else begin
      state_r    <= next_state_s;
      wait_cnt_r <= next_wait_s;
      case ({long_issue_s, slow_accept_s})
        2'b10:   outstanding_r <= outstanding_r + OUT_W'(1);
        2'b01:   outstanding_r <= outstanding_r - OUT_W'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

`ifdef RF_WB_PERF_EN
  // Saturating stall and port-conflict cycle counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_cycles    <= 32'd0;
      perf_conflict_cycles <= 32'd0;
    end else begin
      if (issue_stall && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end else begin
        perf_stall_cycles <= perf_stall_cycles;
      end
      if (slow_valid && fast_valid && (perf_conflict_cycles != 32'hFFFF_FFFF)) begin
        perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
      end else begin
        perf_conflict_cycles <= perf_conflict_cycles;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios then randomized traffic,
// compared against a queue-based model of in-flight long-latency operations.
module tb_regfile_wb_scheduler;

  localparam int STARVE = 4;
  localparam int MAXOUT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, issue_uses_rs1, issue_uses_rs2, issue_writes_rd, issue_long;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_stall;
  logic        fast_valid;
  logic [4:0]  fast_rd;
  logic [31:0] fast_data;
  logic        slow_valid;
  logic [4:0]  slow_rd;
  logic [31:0] slow_data;
  logic        slow_ready;
  logic        rf_write_enable;
  logic [4:0]  rf_rd_address;
  logic [31:0] rf_rd_data;
`ifdef RF_WB_PERF_EN
  logic [31:0] perf_stall_cycles, perf_conflict_cycles;
`endif

  regfile_wb_scheduler #(.STARVE_LIMIT(STARVE), .MAX_OUTSTANDING(MAXOUT)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_uses_rs1(issue_uses_rs1), .issue_uses_rs2(issue_uses_rs2),
    .issue_writes_rd(issue_writes_rd), .issue_long(issue_long), .issue_stall(issue_stall),
    .fast_valid(fast_valid), .fast_rd(fast_rd), .fast_data(fast_data),
    .slow_valid(slow_valid), .slow_rd(slow_rd), .slow_data(slow_data), .slow_ready(slow_ready),
    .rf_write_enable(rf_write_enable), .rf_rd_address(rf_rd_address), .rf_rd_data(rf_rd_data)
`ifdef RF_WB_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_conflict_cycles(perf_conflict_cycles)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: destination of every in-flight long op (0 when it writes nothing / x0).
  int q[$];
  int m_wait  = 0;
  bit m_drain = 1'b0;
  int n_stall = 0;
  int n_conf  = 0;
  bit slow_busy = 1'b0;
  int slow_idx  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_pending(input int r);
    if (r == 0) return 1'b0;
    foreach (q[i]) if (q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int find_idx(input int r);
    foreach (q[i]) if (q[i] == r) return i;
    return 0;
  endfunction

  task automatic begin_cycle();
    @(negedge clock);
    reset = 1'b0; issue_valid = 1'b0; issue_uses_rs1 = 1'b0; issue_uses_rs2 = 1'b0;
    issue_writes_rd = 1'b0; issue_long = 1'b0;
    issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0;
    fast_valid = 1'b0; fast_rd = 5'd0; fast_data = $urandom;
    slow_valid = slow_busy; slow_rd = slow_busy ? 5'(q[slow_idx]) : 5'd0; slow_data = $urandom;
  endtask

  task automatic issue(input bit lng, input int rd, input int rs1);
    issue_valid = 1'b1; issue_long = lng; issue_writes_rd = 1'b1; issue_rd = 5'(rd);
    issue_uses_rs1 = 1'b1; issue_rs1 = 5'(rs1);
  endtask

  task automatic present_slow(input int rd);
    slow_busy = 1'b1; slow_idx = find_idx(rd);
    slow_valid = 1'b1; slow_rd = 5'(rd);
  endtask

  // Compare this cycle's outputs with the model, then advance the model past the coming edge.
  task automatic end_cycle();
    bit ex_stall, ex_ready, acc, ex_we;
    int wrd;
    logic [31:0] wdat;
    #1;
    ex_ready = !fast_valid;
    acc      = slow_valid && ex_ready;
    ex_stall = issue_valid && ((issue_uses_rs1 && m_pending(int'(issue_rs1))) ||
                               (issue_uses_rs2 && m_pending(int'(issue_rs2))) ||
                               (issue_writes_rd && m_pending(int'(issue_rd))) ||
                               (issue_long && q.size() == MAXOUT) || m_drain);
    if (fast_valid) begin
      wrd = int'(fast_rd); wdat = fast_data; ex_we = (wrd != 0);
    end else if (acc) begin
      wrd = int'(slow_rd); wdat = slow_data; ex_we = (wrd != 0);
    end else begin
      wrd = 0; wdat = 32'd0; ex_we = 1'b0;
    end
    check_val("issue_stall", {31'd0, issue_stall}, {31'd0, ex_stall});
    check_val("slow_ready", {31'd0, slow_ready}, {31'd0, ex_ready});
    check_val("rf_we", {31'd0, rf_write_enable}, {31'd0, ex_we});
    if (ex_we) begin
      check_val("rf_addr", {27'd0, rf_rd_address}, 32'(wrd));
      check_val("rf_data", rf_rd_data, wdat);
    end
    if (reset) begin
      q.delete(); m_wait = 0; m_drain = 1'b0; slow_busy = 1'b0; n_stall = 0; n_conf = 0;
    end else begin
      if (ex_stall) n_stall++;
      if (slow_valid && fast_valid) n_conf++;
      if (acc) begin
        q.delete(slow_idx);
        slow_busy = 1'b0;
      end
      if (issue_valid && !ex_stall && issue_long) q.push_back(issue_writes_rd ? int'(issue_rd) : 0);
      if (!m_drain) begin
        if (acc || !slow_valid) m_wait = 0;
        else begin
          m_wait++;
          if (m_wait >= STARVE) m_drain = 1'b1;
        end
      end else if (acc) begin
        m_drain = 1'b0; m_wait = 0;
      end
    end
  endtask

  task automatic reset_cycle();
    begin_cycle(); reset = 1'b1; slow_valid = 1'b0; end_cycle();
  endtask

  task automatic rand_cycle(input int fast_pct);
    begin_cycle();
    if ($urandom_range(0, 299) == 0) begin
      reset = 1'b1; slow_valid = 1'b0;
    end else begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_rs1 = 5'($urandom_range(0, 7)); issue_rs2 = 5'($urandom_range(0, 7));
      issue_rd  = 5'($urandom_range(0, 7));
      issue_uses_rs1 = 1'($urandom_range(0, 1)); issue_uses_rs2 = 1'($urandom_range(0, 1));
      issue_writes_rd = 1'($urandom_range(0, 1)); issue_long = ($urandom_range(0, 2) == 0);
      fast_valid = ($urandom_range(0, 99) < fast_pct);
      fast_rd = 5'($urandom_range(0, 31));
      if (!slow_busy && q.size() > 0 && $urandom_range(0, 2) == 0) begin
        slow_busy = 1'b1; slow_idx = $urandom_range(0, q.size() - 1);
      end
      slow_valid = slow_busy;
      slow_rd = slow_busy ? 5'(q[slow_idx]) : 5'($urandom_range(0, 31));
    end
    end_cycle();
  endtask

  initial begin
    reset_cycle(); reset_cycle();
    // RAW on a long result, then starvation into drain, then reset out of drain.
    begin_cycle(); issue(1'b1, 7, 0); end_cycle();
    begin_cycle(); issue(1'b0, 3, 7); end_cycle();
    check_val("raw_x7", {31'd0, issue_stall}, 32'd1);
    for (int i = 0; i < STARVE; i++) begin
      begin_cycle(); fast_valid = 1'b1; fast_rd = 5'd2; present_slow(7); end_cycle();
    end
    begin_cycle(); fast_valid = 1'b1; fast_rd = 5'd2; present_slow(7); issue(1'b0, 3, 4); end_cycle();
    check_val("drain_stall", {31'd0, issue_stall}, 32'd1);
    reset_cycle();
    begin_cycle(); issue(1'b0, 3, 7); end_cycle();
    check_val("post_reset_x7", {31'd0, issue_stall}, 32'd0);
    // Long op to x0 leaves nothing pending.
    begin_cycle(); issue(1'b1, 0, 0); end_cycle();
    begin_cycle(); issue(1'b0, 6, 0); end_cycle();
    check_val("x0_reader", {31'd0, issue_stall}, 32'd0);
    reset_cycle();
    // Outstanding limit.
    for (int r = 1; r <= 4; r++) begin
      begin_cycle(); issue(1'b1, r, 0); end_cycle();
    end
    begin_cycle(); issue(1'b1, 10, 0); end_cycle();
    check_val("full_long", {31'd0, issue_stall}, 32'd1);
    begin_cycle(); issue(1'b0, 9, 0); end_cycle();
    check_val("full_short", {31'd0, issue_stall}, 32'd0);
    begin_cycle(); present_slow(1); end_cycle();
    begin_cycle(); present_slow(2); issue(1'b1, 11, 0); end_cycle();
    check_val("acc_and_issue", {31'd0, issue_stall}, 32'd0);
    begin_cycle(); issue(1'b1, 12, 0); end_cycle();
    begin_cycle(); issue(1'b1, 13, 0); end_cycle();
    check_val("full_again", {31'd0, issue_stall}, 32'd1);
    reset_cycle();
    // Randomized traffic with varying fast-path pressure.
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 1500; c++) rand_cycle(p == 0 ? 20 : (p == 1 ? 50 : 85));
    end
`ifdef RF_WB_PERF_EN
    #1;
    check_val("perf_stall", perf_stall_cycles, 32'(n_stall));
    check_val("perf_conflict", perf_conflict_cycles, 32'(n_conf));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
